rs232_ser: RTL and testbench

RS-232 serializer: pops bytes from an upstream transmit FIFO and drives them onto a serial line as 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity, no flow control). It is the transmit end of the RS-232 link. A standard-read FIFO (data valid one cycle after read enable) sits between it and the host logic. Line output is registered and glitch-free.

---
 rtl/rs232_ser_pkg.sv | 20 ++
 rtl/rs232_ser_if.sv | 28 ++
 rtl/rs232_ser_baud_tick.sv | 33 +++
 rtl/rs232_ser.sv | 131 +++++++++++++
 tb/tb_rs232_ser.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/rs232_ser_pkg.sv
// Shared RS-232 definitions: 8N1 frame constants and the width helper
// used by both the serializer and the deserializer.
package rs232_ser_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Bits needed to hold the values 0..value-1 (at least 1).
    function automatic int clogb2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if (((value - 1) >> i) != 0) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rs232_ser_if.sv
// Transmit-side bundle: FIFO read port plus the serial line and busy flag.
// master = serializer, slave = FIFO / line consumer.
interface rs232_ser_if;
    import rs232_ser_pkg::*;

    logic [DATA_BITS-1:0] tx_fifo_data;
    logic                 tx_fifo_empty;
    logic                 tx_fifo_rd_en;
    logic                 tx;
    logic                 tx_busy;

    modport master (
        input  tx_fifo_data,
        input  tx_fifo_empty,
        output tx_fifo_rd_en,
        output tx,
        output tx_busy
    );

    modport slave (
        output tx_fifo_data,
        output tx_fifo_empty,
        input  tx_fifo_rd_en,
        input  tx,
        input  tx_busy
    );

endinterface

// File: rtl/rs232_ser_baud_tick.sv
// Clearable bit-period counter. Counts 0..P_N-1 and raises tick during the
// last count, so a timed state lasts exactly P_N clocks. Rolling over to 0
// on tick means the next timed state starts at 0 with no drift.
module rs232_ser_baud_tick
    import rs232_ser_pkg::*;
#(
    parameter int P_N = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int            W  = clogb2(P_N);
    localparam logic [W-1:0]  TC = W'(P_N - 1);

    logic [W-1:0] cnt;

    // Count within a bit period; hold at 0 while cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || cnt == TC) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == TC);

endmodule

// File: rtl/rs232_ser.sv
// RS-232 8N1 serializer: pops one byte from a standard-read FIFO and shifts
// it out LSB first with one start and one stop bit.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | line high, pop FIFO when not empty
//   S_FETCH | pop issued, FIFO data becomes valid next cycle
//   S_LOAD  | capture byte, drive start bit
//   S_START | hold start bit (low) for one bit period
//   S_SHIFT | hold each data bit one period, shift right at its end
//   S_STOP  | hold stop bit (high) for one bit period, then release busy
module rs232_ser
    import rs232_ser_pkg::*;
#(
    parameter int P_CLK_FREQ_HZ = 100000000,
    parameter int P_BAUD_RATE   = 9600
) (
    input  logic            clk,
    input  logic            rst_n,
    rs232_ser_if.master     bus
);

    localparam int N     = P_CLK_FREQ_HZ / P_BAUD_RATE;
    localparam int BIT_W = clogb2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_SHIFT = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] shift;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 tx_r;
    logic                 rd_en_r;
    logic                 busy_r;
    logic                 baud_clr;
    logic                 baud_tick;

    // The bit timer only runs in the line-timed states, so it is zero on
    // entry to S_START and rolls over to zero at every later bit boundary.
    assign baud_clr = (state == S_IDLE) || (state == S_FETCH) || (state == S_LOAD);

    rs232_ser_baud_tick #(
        .P_N (N)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (baud_clr),
        .tick  (baud_tick)
    );

    // Frame sequencer with registered line, pop and busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            tx_r    <= 1'b1;
            rd_en_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_r    <= 1'b1;
                    rd_en_r <= 1'b0;
                    if (!bus.tx_fifo_empty) begin
                        rd_en_r <= 1'b1;
                        busy_r  <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    rd_en_r <= 1'b0;
                    state   <= S_LOAD;
                end
                S_LOAD: begin
                    shift   <= bus.tx_fifo_data;
                    tx_r    <= 1'b0;
                    bit_cnt <= '0;
                    state   <= S_START;
                end
                S_START: begin
                    if (baud_tick) begin
                        tx_r  <= shift[0];
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (baud_tick) begin
                        shift   <= {1'b0, shift[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            tx_r    <= 1'b1;
                            bit_cnt <= '0;
                            state   <= S_STOP;
                        end else begin
                            tx_r <= shift[1];
                        end
                    end
                end
                S_STOP: begin
                    if (baud_tick) begin
                        if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                            busy_r  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    tx_r    <= 1'b1;
                    rd_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx            = tx_r;
    assign bus.tx_fifo_rd_en = rd_en_r;
    assign bus.tx_busy       = busy_r;

endmodule

// File: tb/tb_rs232_ser.sv
// Directed bench for rs232_ser at N = 10 clocks per bit. Line, pop and busy
// are recorded per cycle on the falling edge and checked against
// hand-computed frame timings and byte values.
module tb_rs232_ser;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int N      = CLK_HZ / BAUD;
    localparam int MAXC   = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic tx_hist   [MAXC];
    logic rd_hist   [MAXC];
    logic busy_hist [MAXC];

    rs232_ser_if bus ();

    rs232_ser #(
        .P_CLK_FREQ_HZ (CLK_HZ),
        .P_BAUD_RATE   (BAUD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Cycle index: cycle c lies between posedge c and posedge c+1.
    always @(posedge clk) cyc <= cyc + 1;

    // Record outputs mid-cycle.
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            tx_hist[cyc]   <= bus.tx;
            rd_hist[cyc]   <= bus.tx_fifo_rd_en;
            busy_hist[cyc] <= bus.tx_busy;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int tx_at(input int c);
        return (c >= 0 && c < MAXC) ? int'(tx_hist[c]) : -1;
    endfunction

    function automatic int busy_at(input int c);
        return (c >= 0 && c < MAXC) ? int'(busy_hist[c]) : -1;
    endfunction

    function automatic int count_rd(input int a, input int b);
        int n;
        n = 0;
        for (int c = a; c < b; c++) begin
            if (c >= 0 && c < MAXC && rd_hist[c] === 1'b1) n++;
        end
        return n;
    endfunction

    function automatic int count_tx0(input int a, input int b);
        int n;
        n = 0;
        for (int c = a; c < b; c++) begin
            if (c >= 0 && c < MAXC && tx_hist[c] !== 1'b1) n++;
        end
        return n;
    endfunction

    function automatic int find_fall(input int a, input int b);
        for (int c = a; c < b; c++) begin
            if (c > 0 && c < MAXC && tx_hist[c] === 1'b0 && tx_hist[c-1] === 1'b1) return c;
        end
        return -1;
    endfunction

    // Mid-bit sampling UART; -1 for bad start index, -2 for framing error.
    function automatic int decode(input int s);
        int b;
        b = 0;
        if (s < 0 || s + 10 * N >= MAXC) return -1;
        if (tx_hist[s + N/2] !== 1'b0 || tx_hist[s + 9*N + N/2] !== 1'b1) return -2;
        for (int i = 0; i < 8; i++) begin
            if (tx_hist[s + N*(i+1) + N/2] === 1'b1) b = b | (1 << i);
        end
        return b;
    endfunction

    task automatic wait_rd(input int budget, output int k);
        k = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.tx_fifo_rd_en === 1'b1) begin
                k = cyc;
                break;
            end
        end
        chk("rd_seen", int'(k >= 0), 1);
    endtask

    initial begin
        int r, k, k1, k2, s1, s2, a, ok;
        int bad_tx, bad_rd, bad_busy;
        logic [9:0] pat;

        // Reset held with a non-empty FIFO
        bus.tx_fifo_empty = 1'b0;
        bus.tx_fifo_data  = 8'hA5;
        rst_n = 1'b0;
        bad_tx = 0; bad_rd = 0; bad_busy = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) bad_tx++;
            if (bus.tx_fifo_rd_en !== 1'b0) bad_rd++;
            if (bus.tx_busy !== 1'b0) bad_busy++;
        end
        chk("rst_tx_not_idle_cycles", bad_tx, 0);
        chk("rst_rd_cycles", bad_rd, 0);
        chk("rst_busy_cycles", bad_busy, 0);
        rst_n = 1'b1;
        r = cyc;
        wait_rd(10, k);
        chk("rst_first_rd_cycle", k, r + 1);
        bus.tx_fifo_empty = 1'b1;
        repeat (120) @(negedge clk);

        // Single byte 0xA5: line 0,1,0,1,0,0,1,0,1,1
        chk("a5_rd_pulses", count_rd(k, k + 120), 1);
        chk("a5_tx_idle_before", tx_at(k + 1), 1);
        chk("a5_first_low", find_fall(k, k + 20), k + 2);
        pat = {1'b1, 8'hA5, 1'b0};
        for (int j = 0; j < 10; j++) begin
            ok = 0;
            for (int c = 0; c < N; c++) begin
                if (tx_at(k + 2 + N*j + c) == int'(pat[j])) ok++;
            end
            chk($sformatf("a5_bit%0d_cycles", j), ok, N);
        end
        chk("a5_busy_at_rd", busy_at(k), 1);
        chk("a5_busy_before_rd", busy_at(k - 1), 0);
        chk("a5_busy_last", busy_at(k + 101), 1);
        chk("a5_busy_drop", busy_at(k + 102), 0);

        // Back-to-back 0x00 then 0xFF
        bus.tx_fifo_data  = 8'h00;
        bus.tx_fifo_empty = 1'b0;
        wait_rd(10, k1);
        @(negedge clk);
        @(negedge clk);
        bus.tx_fifo_data = 8'hFF;
        wait_rd(200, k2);
        bus.tx_fifo_empty = 1'b1;
        repeat (120) @(negedge clk);
        chk("b2b_rd_gap", k2 - k1, 103);
        chk("b2b_rd_pulses", count_rd(k1, k2 + 110), 2);
        s1 = find_fall(k1, k1 + 20);
        chk("b2b_start0", s1, k1 + 2);
        chk("b2b_byte0", decode(s1), 8'h00);
        s2 = find_fall(s1 + 1, s1 + 200);
        chk("b2b_start_gap", s2 - s1, 10*N + 3);
        chk("b2b_byte1", decode(s2), 8'hFF);

        // Empty FIFO for 1000 cycles
        a = cyc;
        repeat (1000) @(negedge clk);
        chk("empty_rd_pulses", count_rd(a, cyc), 0);
        chk("empty_tx_low_cycles", count_tx0(a, cyc), 0);

        // Empty deasserted mid-frame has no effect until S_IDLE
        bus.tx_fifo_data  = 8'h5A;
        bus.tx_fifo_empty = 1'b0;
        wait_rd(10, k);
        bus.tx_fifo_empty = 1'b1;
        repeat (30) @(negedge clk);
        bus.tx_fifo_empty = 1'b0;
        wait_rd(150, k2);
        bus.tx_fifo_empty = 1'b1;
        chk("midempty_next_rd_gap", k2 - k, 103);
        repeat (120) @(negedge clk);
        chk("midempty_rd_pulses", count_rd(k, k2 + 110), 2);

        // Reset during data bit 3 of 0x55
        bus.tx_fifo_data  = 8'h55;
        bus.tx_fifo_empty = 1'b0;
        wait_rd(10, k);
        bus.tx_fifo_empty = 1'b1;
        repeat (45) @(negedge clk);
        chk("rstmid_bit3_low", int'(bus.tx), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_tx_async", int'(bus.tx), 1);
        chk("rstmid_busy_async", int'(bus.tx_busy), 0);
        bad_tx = 0; bad_rd = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) bad_tx++;
            if (bus.tx_fifo_rd_en !== 1'b0) bad_rd++;
        end
        chk("rstmid_tx_low_cycles", bad_tx, 0);
        chk("rstmid_rd_cycles", bad_rd, 0);
        rst_n = 1'b1;
        a = cyc;
        repeat (200) @(negedge clk);
        chk("rstmid_after_tx_low", count_tx0(a, cyc), 0);
        chk("rstmid_after_rd", count_rd(a, cyc), 0);

        // Data changes after capture do not affect the frame
        bus.tx_fifo_data  = 8'hC3;
        bus.tx_fifo_empty = 1'b0;
        wait_rd(10, k);
        bus.tx_fifo_empty = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.tx_fifo_data = 8'h3C;
        repeat (115) @(negedge clk);
        s1 = find_fall(k, k + 20);
        chk("hold_start", s1, k + 2);
        chk("hold_byte", decode(s1), 8'hC3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
